calc_unit_mc: RTL and testbench

- Parametrised multi-cycle execute stage for the processor datapath.
- Latches operand registers A and B, selects ALU sources (PC, increment constant, A, B, immediate), and computes the result.
- Registers the result with Zero/Negative flags into ALUOut and drives the PC-source mux.
- Generalises the 16-bit single-cycle version: configurable width, a valid/ready handshake, shift ops, and an iterative shift-add multiply taking WIDTH cycles.

---
 rtl/calc_unit_mc.sv | 176 +++++++++++++++++
 tb/tb_calc_unit_mc.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/calc_unit_mc.sv
// Multi-cycle execute stage: captures operands on a valid/ready handshake, runs a
// one-cycle ALU op or a WIDTH-cycle shift-add multiply, and registers result and flags.
module calc_unit_mc #(
  parameter int          WIDTH     = 16,
  parameter int unsigned INC_CONST = 2,
  parameter int          SHW       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input_A,
  input  logic [WIDTH-1:0] input_B,
  input  logic [WIDTH-1:0] input_PC,
  input  logic [WIDTH-1:0] input_imm,
  input  logic [1:0]       input_ALUSrcA,
  input  logic [1:0]       input_ALUSrcB,
  input  logic [2:0]       input_ALUOp,
  input  logic             input_PCSrc,
  output logic             out_valid,
  output logic [WIDTH-1:0] output_ALUOut,
  output logic [WIDTH-1:0] output_ALUMuxOut,
  output logic             output_Zero,
  output logic             output_negative,
  output logic [WIDTH-1:0] output_B_sr
);

  localparam logic [WIDTH-1:0] INC_W    = WIDTH'(INC_CONST);
  localparam logic [SHW-1:0]   CNT_LAST = SHW'(WIDTH - 1);
  localparam logic [2:0]       OP_MUL   = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, pc_q, imm_q;
  logic [1:0]       srca_q, srcb_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] aluout_q;
  logic             zero_q, neg_q;
  logic [WIDTH-1:0] mcand_q, mplier_q, prod_q;
  logic [SHW-1:0]   cnt_q;

  logic             accept, wr_res;
  logic [WIDTH-1:0] src_a, src_b, alu_res, alu_live, mul_step, res_d;
  logic [WIDTH-1:0] in_src_a, in_src_b;

  function automatic logic [WIDTH-1:0] mux_a(input logic [1:0] sel,
                                             input logic [WIDTH-1:0] pc,
                                             input logic [WIDTH-1:0] a);
    case (sel)
      2'd0:    return pc;
      2'd1:    return INC_W;
      2'd2:    return a;
      default: return '0;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] mux_b(input logic [1:0] sel,
                                             input logic [WIDTH-1:0] b,
                                             input logic [WIDTH-1:0] imm);
    case (sel)
      2'd0:    return b;
      2'd1:    return INC_W;
      2'd2:    return imm;
      default: return '0;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] alu(input logic [2:0] op,
                                           input logic [WIDTH-1:0] x,
                                           input logic [WIDTH-1:0] y);
    case (op)
      3'd0:    return x + y;
      3'd1:    return x - y;
      3'd2:    return x & y;
      3'd3:    return x | y;
      3'd4:    return x ^ y;
      3'd5:    return x << y[SHW-1:0];
      3'd6:    return $unsigned($signed(x) >>> y[SHW-1:0]);
      default: return '0;
    endcase
  endfunction

  assign src_a    = mux_a(srca_q, pc_q, a_q);
  assign src_b    = mux_b(srcb_q, b_q, imm_q);
  assign in_src_a = mux_a(input_ALUSrcA, input_PC, input_A);
  assign in_src_b = mux_b(input_ALUSrcB, input_B, input_imm);
  assign alu_res  = alu(op_q, src_a, src_b);
  // During a multiply the live result is the running partial product
  assign alu_live = (op_q == OP_MUL) ? prod_q : alu_res;
  assign mul_step = prod_q + (mplier_q[0] ? mcand_q : '0);

  assign in_ready         = (state_q == S_IDLE) && !reset;
  assign out_valid        = (state_q == S_DONE);
  assign output_ALUOut    = aluout_q;
  assign output_Zero      = zero_q;
  assign output_negative  = neg_q;
  assign output_B_sr      = b_q;
  assign output_ALUMuxOut = input_PCSrc ? aluout_q : alu_live;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    wr_res  = 1'b0;
    res_d   = alu_res;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          accept  = 1'b1;
          state_d = (input_ALUOp == OP_MUL) ? S_MUL : S_EXEC;
        end
      end
      S_EXEC: begin
        wr_res  = 1'b1;
        state_d = S_DONE;
      end
      S_MUL: begin
        if (cnt_q == CNT_LAST) begin
          wr_res  = 1'b1;
          res_d   = mul_step;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      pc_q     <= '0;
      imm_q    <= '0;
      srca_q   <= '0;
      srcb_q   <= '0;
      op_q     <= '0;
      aluout_q <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      if (accept) begin
        a_q      <= input_A;
        b_q      <= input_B;
        pc_q     <= input_PC;
        imm_q    <= input_imm;
        srca_q   <= input_ALUSrcA;
        srcb_q   <= input_ALUSrcB;
        op_q     <= input_ALUOp;
        mcand_q  <= in_src_a;
        mplier_q <= in_src_b;
        prod_q   <= '0;
        cnt_q    <= '0;
      end else if (state_q == S_MUL) begin
        prod_q   <= mul_step;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + 1'b1;
      end
      if (wr_res) begin
        aluout_q <= res_d;
        zero_q   <= (res_d == '0);
        neg_q    <= res_d[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_calc_unit_mc.sv
// Randomized and directed checks of calc_unit_mc against an arithmetic reference model.
module tb_calc_unit_mc;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, pcsrc, out_valid, zero, neg;
  logic [15:0] in_a, in_b, in_pc, in_imm, aluout, muxout, b_sr;
  logic [1:0]  sa, sb;
  logic [2:0]  op;

  logic        in_valid_w, in_ready_w, pcsrc_w, out_valid_w, zero_w, neg_w;
  logic [31:0] in_a_w, in_b_w, in_pc_w, in_imm_w, aluout_w, muxout_w, b_sr_w;
  logic [1:0]  sa_w, sb_w;
  logic [2:0]  op_w;

  calc_unit_mc dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .input_A(in_a), .input_B(in_b), .input_PC(in_pc), .input_imm(in_imm),
    .input_ALUSrcA(sa), .input_ALUSrcB(sb), .input_ALUOp(op), .input_PCSrc(pcsrc),
    .out_valid(out_valid), .output_ALUOut(aluout), .output_ALUMuxOut(muxout),
    .output_Zero(zero), .output_negative(neg), .output_B_sr(b_sr)
  );

  calc_unit_mc #(.WIDTH(32), .INC_CONST(4)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .input_A(in_a_w), .input_B(in_b_w), .input_PC(in_pc_w), .input_imm(in_imm_w),
    .input_ALUSrcA(sa_w), .input_ALUSrcB(sb_w), .input_ALUOp(op_w), .input_PCSrc(pcsrc_w),
    .out_valid(out_valid_w), .output_ALUOut(aluout_w), .output_ALUMuxOut(muxout_w),
    .output_Zero(zero_w), .output_negative(neg_w), .output_B_sr(b_sr_w)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic reduced mod 2^16
  function automatic logic [15:0] ref16(input logic [2:0] f, input logic [15:0] x,
                                        input logic [15:0] y);
    longint ux, uy, sx, d, q;
    int amt;
    ux  = longint'(x);
    uy  = longint'(y);
    amt = int'(y % 16);
    d   = longint'(1) << amt;
    case (f)
      3'd0: q = ux + uy;
      3'd1: q = ux - uy + 65536;
      3'd2: q = longint'(x & y);
      3'd3: q = longint'(x | y);
      3'd4: q = longint'(x ^ y);
      3'd5: q = ux * d;
      3'd6: begin
        sx = (ux >= 32768) ? ux - 65536 : ux;
        q  = sx / d;
        if (sx < 0 && (sx % d) != 0) q = q - 1;
        q = q + 65536;
      end
      default: q = ux * uy;
    endcase
    return 16'(q % 65536);
  endfunction

  function automatic logic [15:0] pick_a(input logic [1:0] s, input logic [15:0] p,
                                         input logic [15:0] a);
    return (s == 2'd0) ? p : (s == 2'd1) ? 16'd2 : (s == 2'd2) ? a : 16'd0;
  endfunction

  function automatic logic [15:0] pick_b(input logic [1:0] s, input logic [15:0] b,
                                         input logic [15:0] i);
    return (s == 2'd0) ? b : (s == 2'd1) ? 16'd2 : (s == 2'd2) ? i : 16'd0;
  endfunction

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] p,
                        input logic [15:0] i, input logic [1:0] s_a, input logic [1:0] s_b,
                        input logic [2:0] f, output logic [15:0] res);
    logic [15:0] exp;
    int lat, waited;
    bit seen;
    exp = ref16(f, pick_a(s_a, p, a), pick_b(s_b, b, i));
    waited = 0;
    while (!in_ready && waited < 40) begin @(negedge clk); waited++; end
    check("ready_before", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_a = a; in_b = b; in_pc = p; in_imm = i; sa = s_a; sb = s_b; op = f;
    pcsrc = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("live_mux", 64'(muxout), 64'((f == 3'd7) ? 16'd0 : exp));
    seen = 0; lat = 0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) seen = 1;
      else check("busy_ready", 64'(in_ready), 64'd0);
    end
    check("latency", 64'(lat), 64'((f == 3'd7) ? 16 : 1));
    check("aluout", 64'(aluout), 64'(exp));
    check("zero", 64'(zero), 64'(exp == 16'd0));
    check("neg", 64'(neg), 64'(exp[15]));
    check("b_sr", 64'(b_sr), 64'(b));
    pcsrc = 1'b1; #1;
    check("mux_reg", 64'(muxout), 64'(exp));
    @(posedge clk); #1;
    check("pulse_len", 64'(out_valid), 64'd0);
    res = aluout;
  endtask

  logic [15:0] r;
  int cyc;

  initial begin
    in_valid = 0; pcsrc = 1; in_a = 0; in_b = 0; in_pc = 0; in_imm = 0; sa = 0; sb = 0; op = 0;
    in_valid_w = 0; pcsrc_w = 1; in_a_w = 0; in_b_w = 0; in_pc_w = 0; in_imm_w = 0;
    sa_w = 0; sb_w = 0; op_w = 0;
    #2;
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_aluout", 64'(aluout), 64'd0);
    check("rst_flags", 64'({zero, neg}), 64'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    #1 check("rel_ready", 64'(in_ready), 64'd1);

    run_op(16'h0, 16'h0, 16'h0040, 16'h0, 2'd0, 2'd1, 3'd0, r);
    check("add_pc_inc", 64'(r), 64'h0042);
    run_op(16'h1234, 16'h1234, 16'h0, 16'h0, 2'd2, 2'd0, 3'd1, r);
    check("sub_zero", 64'(r), 64'h0000);
    run_op(16'h0001, 16'h0002, 16'h0, 16'h0, 2'd2, 2'd0, 3'd1, r);
    check("sub_neg", 64'(r), 64'hFFFF);
    run_op(16'h0003, 16'h0, 16'h0, 16'h0005, 2'd2, 2'd2, 3'd7, r);
    check("mul_3x5", 64'(r), 64'h000F);
    run_op(16'h0100, 16'h0, 16'h0, 16'h0100, 2'd2, 2'd2, 3'd7, r);
    check("mul_wrap", 64'(r), 64'h0000);
    run_op(16'h8000, 16'h0, 16'h0, 16'h0004, 2'd2, 2'd2, 3'd6, r);
    check("sra", 64'(r), 64'hF800);
    run_op(16'h0001, 16'h0, 16'h0, 16'h0013, 2'd2, 2'd2, 3'd5, r);
    check("sll", 64'(r), 64'h0008);
    run_op(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 2'd3, 2'd3, 3'd3, r);
    check("or_zero_sel", 64'(r), 64'h0000);

    for (int k = 0; k < 40; k++) begin
      run_op(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
             2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), r);
    end

    // New requests held high during a multiply must wait for IDLE
    @(negedge clk);
    in_a = 16'd7; in_imm = 16'd9; in_b = 16'h1111; sa = 2'd2; sb = 2'd2; op = 3'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_a = 16'd5; in_b = 16'h2222; sb = 2'd0; op = 3'd0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1; cyc++;
      check("held_bsr", 64'(b_sr), 64'h1111);
    end
    check("held_lat", 64'(cyc), 64'd16);
    check("held_mul", 64'(aluout), 64'd63);
    @(posedge clk); #1;
    check("held_idle_bsr", 64'(b_sr), 64'h1111);
    check("held_idle_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("held_accept_bsr", 64'(b_sr), 64'h2222);
    @(posedge clk); #1;
    check("held_add_valid", 64'(out_valid), 64'd1);
    check("held_add", 64'(aluout), 64'h2227);
    @(posedge clk); #1;

    // Abort a multiply with reset
    @(negedge clk);
    in_a = 16'd3; in_imm = 16'd3; in_b = 16'h5555; sa = 2'd2; sb = 2'd2; op = 3'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_ready", 64'(in_ready), 64'd0);
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_aluout", 64'(aluout), 64'd0);
    check("abort_flags", 64'({zero, neg}), 64'd0);
    check("abort_bsr", 64'(b_sr), 64'd0);
    check("abort_mux", 64'(muxout), 64'd0);
    repeat (3) begin @(posedge clk); #1; check("abort_no_pulse", 64'(out_valid), 64'd0); end
    @(negedge clk);
    reset = 1'b0;
    run_op(16'h0010, 16'h0020, 16'h0, 16'h0, 2'd2, 2'd0, 3'd0, r);
    check("post_abort_add", 64'(r), 64'h0030);

    // 32-bit instance with INC_CONST=4
    @(negedge clk);
    in_pc_w = 32'h1000_0000; sa_w = 2'd0; sb_w = 2'd1; op_w = 3'd0; in_valid_w = 1'b1;
    @(posedge clk); #1;
    in_valid_w = 1'b0;
    @(posedge clk); #1;
    check("w32_valid", 64'(out_valid_w), 64'd1);
    check("w32_add_inc", 64'(aluout_w), 64'h1000_0004);
    @(posedge clk); #1;
    @(negedge clk);
    in_a_w = 32'h0001_0003; in_b_w = 32'h0002_0005; sa_w = 2'd2; sb_w = 2'd0; op_w = 3'd7;
    in_valid_w = 1'b1;
    @(posedge clk); #1;
    in_valid_w = 1'b0;
    cyc = 0;
    while (!out_valid_w && cyc < 80) begin @(posedge clk); #1; cyc++; end
    check("w32_mul_lat", 64'(cyc), 64'd32);
    check("w32_mul", 64'(aluout_w), 64'((64'h0001_0003 * 64'h0002_0005) % 64'h1_0000_0000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
